toysram_rf_2r1w: RTL

TOYSRAM_RF_2R1W -- requirements
Module: toysram_rf_2r1w

---
 rtl/toysram_pkg.sv | 25 ++
 rtl/toysram_dec.sv | 23 ++
 rtl/toysram_rf_2r1w.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/toysram_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
// State encoding, error bit positions and address width calculation.
package toysram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int ERR_ADDR = 0;
    localparam int ERR_NRDY = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/toysram_dec.sv
// Address decoder: one-hot word select plus out-of-range flag.
// Both outputs are gated by the request enable.
module toysram_dec
    import toysram_pkg::*;
#(
    parameter int WORDS = 16,
    parameter int AW    = clog2(WORDS)
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [WORDS-1:0] hot,
    output logic             oor
);

    always_comb begin
        hot = '0;
        oor = en && (32'(addr) >= 32'(WORDS));
        for (int i = 0; i < WORDS; i++) begin
            hot[i] = en && (32'(addr) == 32'(i));
        end
    end

endmodule

// File: rtl/toysram_rf_2r1w.sv
// Flop-based register file, two registered read ports and one masked
// write port, zero-filled by a sequential INIT sweep after reset.
module toysram_rf_2r1w
    import toysram_pkg::*;
#(
    parameter int WORDS  = 16,
    parameter int BITS   = 12,
    parameter int BYPASS = 1,
    localparam int AW    = clog2(WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd0_en,
    input  logic [AW-1:0]   rd0_addr,
    output logic [BITS-1:0] rd0_data,
    output logic            rd0_valid,
    input  logic            rd1_en,
    input  logic [AW-1:0]   rd1_addr,
    output logic [BITS-1:0] rd1_data,
    output logic            rd1_valid,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    input  logic [BITS-1:0] wr_mask,
    output logic            ready,
    output logic [1:0]      err,
    input  logic            err_clr
);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [BITS-1:0] mem_q [WORDS];
    logic [BITS-1:0] mem_d [WORDS];
    logic [BITS-1:0] rd0_data_q, rd0_data_d;
    logic [BITS-1:0] rd1_data_q, rd1_data_d;
    logic            rd0_valid_q, rd0_valid_d;
    logic            rd1_valid_q, rd1_valid_d;
    logic [1:0]      err_q, err_d;

    logic [WORDS-1:0] wr_hot, rd0_hot, rd1_hot;
    logic             wr_oor, rd0_oor, rd1_oor;
    logic             is_ready, in_init, last_word;
    logic             wr_go, rd0_go, rd1_go, byp0, byp1;
    logic [BITS-1:0]  wr_old, merged, rd0_word, rd1_word;
    logic [1:0]       new_err;

    toysram_dec #(.WORDS(WORDS), .AW(AW)) u_dec_wr (
        .en   (wr_en),
        .addr (wr_addr),
        .hot  (wr_hot),
        .oor  (wr_oor)
    );

    toysram_dec #(.WORDS(WORDS), .AW(AW)) u_dec_rd0 (
        .en   (rd0_en),
        .addr (rd0_addr),
        .hot  (rd0_hot),
        .oor  (rd0_oor)
    );

    toysram_dec #(.WORDS(WORDS), .AW(AW)) u_dec_rd1 (
        .en   (rd1_en),
        .addr (rd1_addr),
        .hot  (rd1_hot),
        .oor  (rd1_oor)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign last_word = (32'(ptr_q) == 32'(WORDS - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + AW'(1);
                if (last_word) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_comb begin
        is_ready = (state_q == ST_READY);
        in_init  = (state_q == ST_INIT);
        ready    = is_ready;
    end

    always_comb begin
        wr_old   = '0;
        rd0_word = '0;
        rd1_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            wr_old   = wr_old   | (mem_q[i] & {BITS{wr_hot[i]}});
            rd0_word = rd0_word | (mem_q[i] & {BITS{rd0_hot[i]}});
            rd1_word = rd1_word | (mem_q[i] & {BITS{rd1_hot[i]}});
        end
        merged = (wr_old & ~wr_mask) | (wr_data & wr_mask);
        wr_go  = is_ready && wr_en && !wr_oor;
        rd0_go = is_ready && rd0_en && !rd0_oor;
        rd1_go = is_ready && rd1_en && !rd1_oor;
        // Hot vectors match only when both ports hit the same in-range word
        byp0   = (BYPASS != 0) && wr_go && (rd0_hot == wr_hot);
        byp1   = (BYPASS != 0) && wr_go && (rd1_hot == wr_hot);
    end

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            mem_d[i] = mem_q[i];
            if (in_init && (32'(ptr_q) == 32'(i))) begin
                mem_d[i] = '0;
            end else if (wr_go && wr_hot[i]) begin
                mem_d[i] = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORDS; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        rd0_valid_d = rd0_go;
        rd1_valid_d = rd1_go;
        rd0_data_d  = rd0_data_q;
        rd1_data_d  = rd1_data_q;
        if (rd0_go) begin
            rd0_data_d = byp0 ? merged : rd0_word;
        end
        if (rd1_go) begin
            rd1_data_d = byp1 ? merged : rd1_word;
        end
        new_err           = '0;
        new_err[ERR_ADDR] = rd0_oor || rd1_oor || wr_oor;
        new_err[ERR_NRDY] = !is_ready && (rd0_en || rd1_en || wr_en);
        err_d             = (err_clr ? 2'b00 : err_q) | new_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd0_data_q  <= '0;
            rd1_data_q  <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            rd0_data_q  <= rd0_data_d;
            rd1_data_q  <= rd1_data_d;
            rd0_valid_q <= rd0_valid_d;
            rd1_valid_q <= rd1_valid_d;
            err_q       <= err_d;
        end
    end

    assign rd0_data  = rd0_data_q;
    assign rd1_data  = rd1_data_q;
    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;
    assign err       = err_q;

endmodule
